io_periph_ctrl: RTL and testbench
=================================

// Module: io_periph_ctrl
// PURPOSE
//  Memory-mapped board-IO peripheral, parametrised successor to the fixed top-level IO tie-offs.
//  Sits behind the memory controller's IO address decode; owns LEDs, debounced switches and a
//  multiplexed N-digit seven-segment display. Flags switch changes with a one-cycle pulse.
// PARAMETERS
//  NUM_SW        16        switch inputs (1..32)
//  NUM_LED       16        LED outputs (1..32)
//  NUM_DIGITS    8         seven-seg digits scanned (1..8)
//  REFRESH_DIV   100000    clk cycles each digit is lit (>=2)
//  DEBOUNCE_DIV  2000000   clk cycles between switch samples (>=2)
// PORTS
//  clk_in         in   1           system clock; only clock
//  rst_high_in    in   1           reset, asynchronous, active-high
//  cs_in          in   1           chip select from memory-controller decode
//  addr_in        in   4           byte offset; [3:2] select register, [1:0] ignored
//  wr_data_in     in   32          write data
//  we_in          in   1           write strobe, qualified by cs_in
//  rd_data_out    out  32          registered read data
//  sw_in          in   NUM_SW      raw asynchronous switches
//  sw_change_out  out  1           1-cycle pulse when debounced switch value changes
//  led_out        out  NUM_LED     LED drive, active-high
//  sseg_out       out  7           segments {g..a}, active-low
//  dp_out         out  1           decimal point, active-low
//  an_out         out  NUM_DIGITS  anodes, active-low
// BEHAVIOUR
//  Reset (async assert, sync deassert by upstream): led=0, rd_data=0, sw_change=0, debounced sw=0,
//   SSEG_DATA=0, SSEG_CTRL=0, digit index=0, counters=0, an_out all 1, sseg_out 7'h7F, dp_out 1.
//  Register map (word offset addr_in[3:2]):
//   0 LED   RW  [NUM_LED-1:0]; upper bits read 0, write-ignored
//   1 SW    RO  debounced switches, zero-extended; writes ignored
//   2 DATA  RW  nibble k = hex value of digit k (digit 0 = bits[3:0])
//   3 CTRL  RW  [7:0] digit enable mask, [15:8] dp mask (1 = dp lit); others read 0
//  Bits for digits >= NUM_DIGITS are stored as 0 and read 0.
//  Write: cs_in&&we_in at edge N -> register updated at N; outputs reflect it from N+1.
//  Read: cs_in&&!we_in at edge N -> rd_data_out valid after N (1-cycle latency); holds otherwise.
//   Read and write same cycle (we high): rd_data_out unchanged; no read occurs.
//  Switch path: 2-FF synchroniser per bit; free-running sample counter 0..DEBOUNCE_DIV-1;
//   at wrap sample synced bits; debounced bit takes sample only if equal to previous sample.
//   sw_change_out=1 for exactly the cycle after any debounced bit changes.
//  Scan FSM: refresh counter 0..REFRESH_DIV-1; at terminal count digit index increments,
//   wrapping NUM_DIGITS-1 -> 0. Active digit k: an_out[k]=0 iff CTRL enable[k]; others 1.
//   sseg_out = hex decode(nibble k) (0-9,A-F, active-low); dp_out = ~dp[k] when enabled.
//   Disabled digit: an 1, sseg 7'h7F, dp 1 (still occupies its time slot).
//   Outputs registered: change on the cycle after index update; no ghosting glitch.
//  DATA/CTRL writes take effect on the next refresh-slot output update, without resetting the scan.
//  Reset mid-scan: index and counters return to 0 immediately; displays blank until enables set.
// STRUCTURE
//  io_periph_pkg: register offset localparams, SEG_BLANK=7'h7F, function hex_to_sseg(nibble).
//  Sub-module sseg_scan (refresh counter, index, decode, output regs); bus, LED and debounce
//  logic stay in io_periph_ctrl.
// TESTING
//  T1 reset mid-operation: rst_high_in pulse -> all outputs at reset values within same cycle.
//  T2 write LED 0xA5A5, read offset 0 -> led_out=16'hA5A5 next cycle, rd_data=0x0000A5A5 1 cycle
//     after read; write SW offset 4 -> SW reg unchanged.
//  T3 NUM_DIGITS=4, REFRESH_DIV=4, DATA=0x4321, CTRL=0x000F -> an 1110/1101/1011/0111 each 4 cycles,
//     sseg 7'h79,7'h24,7'h30,7'h19, then wrap to digit 0.
//  T4 CTRL=0x0205 -> digits 1,3 an=1 and sseg 7'h7F in their slots; digit 1 dp stays 1 (disabled).
//  T5 DEBOUNCE_DIV=8, sw[0] bounces 0/1 every 3 cycles for 40 cycles then holds 1 -> debounced
//     bit rises within 2 sample periods after settling, single sw_change_out pulse, no earlier pulse.
//  T6 read DATA while writing DATA same cycle -> rd_data unchanged; following read returns new value.

Source files
------------

// File: rtl/io_periph_pkg.sv
// io_periph_pkg: register offsets, blank pattern and hex-to-segment
// decode shared by the board-IO peripheral and its display scanner.
package io_periph_pkg;

   localparam logic [1:0] REG_LED  = 2'd0;
   localparam logic [1:0] REG_SW   = 2'd1;
   localparam logic [1:0] REG_DATA = 2'd2;
   localparam logic [1:0] REG_CTRL = 2'd3;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Segments {g..a}, active-low.
   function automatic logic [6:0] hex_to_sseg(
      input logic [3:0] nib
   );
      logic [6:0] seg;
      seg = SEG_BLANK;
      unique case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/io_periph_ctrl_sseg_scan.sv
// sseg_scan: time-multiplexes NUM_DIGITS hex digits onto one segment bus.
// Ports: clk/rst, digit_data/en/dp from regs; registered sseg, dp, an.
module sseg_scan
   import io_periph_pkg::*;
#(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           digit_data,
   input  logic [7:0]            digit_en,
   input  logic [7:0]            digit_dp,
   output logic [6:0]            sseg,
   output logic                  dp,
   output logic [NUM_DIGITS-1:0] an
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam int IW =
      (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST =
      CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST =
      IW'(NUM_DIGITS - 1);

   logic [CW-1:0]         cnt_q;
   logic [IW-1:0]         idx_q;
   logic                  load_q;
   logic                  tc;
   logic [2:0]            sel;
   logic [3:0]            nib;
   logic [6:0]            sseg_n;
   logic                  dp_n;
   logic [NUM_DIGITS-1:0] an_n;

   assign tc = (cnt_q == CNT_LAST);

   always_comb begin
      sel    = 3'(idx_q);
      nib    = digit_data[{sel, 2'b00} +: 4];
      sseg_n = SEG_BLANK;
      dp_n   = 1'b1;
      an_n   = '1;
      if (digit_en[sel]) begin
         an_n[idx_q] = 1'b0;
         sseg_n      = hex_to_sseg(nib);
         dp_n        = ~digit_dp[sel];
      end
   end

   // load_q is set out of reset so digit 0 gets its first slot,
   // then pulses one cycle after each index step.  Outputs load
   // only then, so register writes land on a slot boundary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         idx_q  <= '0;
         load_q <= 1'b1;
         sseg   <= SEG_BLANK;
         dp     <= 1'b1;
         an     <= '1;
      end else begin
         load_q <= tc;
         if (tc) begin
            cnt_q <= '0;
            if (idx_q == IDX_LAST) idx_q <= '0;
            else                   idx_q <= idx_q + 1'b1;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (load_q) begin
            sseg <= sseg_n;
            dp   <= dp_n;
            an   <= an_n;
         end
      end
   end

endmodule

// File: rtl/io_periph_ctrl.sv
// io_periph_ctrl: memory-mapped LEDs, debounced switches, 7-seg display.
// Ports: clk/rst, cs/addr/wdata/we bus, rd_data, sw, sw_change, led, sseg.
module io_periph_ctrl
   import io_periph_pkg::*;
#(
   parameter int NUM_SW       = 16,
   parameter int NUM_LED      = 16,
   parameter int NUM_DIGITS   = 8,
   parameter int REFRESH_DIV  = 100000,
   parameter int DEBOUNCE_DIV = 2000000
) (
   input  logic                  clk_in,
   input  logic                  rst_high_in,
   input  logic                  cs_in,
   input  logic [3:0]            addr_in,
   input  logic [31:0]           wr_data_in,
   input  logic                  we_in,
   output logic [31:0]           rd_data_out,
   input  logic [NUM_SW-1:0]     sw_in,
   output logic                  sw_change_out,
   output logic [NUM_LED-1:0]    led_out,
   output logic [6:0]            sseg_out,
   output logic                  dp_out,
   output logic [NUM_DIGITS-1:0] an_out
);

   localparam int DW = $clog2(DEBOUNCE_DIV);
   localparam logic [DW-1:0] DB_LAST =
      DW'(DEBOUNCE_DIV - 1);
   // Bits belonging to absent digits are forced to 0.
   localparam logic [31:0] DATA_MASK =
      32'((64'd1 << (4 * NUM_DIGITS)) - 64'd1);
   localparam logic [7:0] DIG_MASK =
      8'((16'd1 << NUM_DIGITS) - 16'd1);

   logic [1:0]         reg_sel;
   logic               wr;
   logic               rd;
   logic               addr_unused;
   logic [31:0]        rd_mux;
   logic [NUM_LED-1:0] led_q;
   logic [31:0]        data_q;
   logic [7:0]         en_q;
   logic [7:0]         dp_q;

   logic [NUM_SW-1:0]  sw_meta;
   logic [NUM_SW-1:0]  sw_sync;
   logic [NUM_SW-1:0]  sw_samp;
   logic [NUM_SW-1:0]  sw_deb;
   logic [NUM_SW-1:0]  sw_agree;
   logic [NUM_SW-1:0]  sw_deb_n;
   logic [DW-1:0]      db_cnt;
   logic               db_tc;
   logic               sw_change_q;

   assign reg_sel     = addr_in[3:2];
   assign addr_unused = ^addr_in[1:0];
   assign wr          = cs_in && we_in;
   assign rd          = cs_in && !we_in;

   always_comb begin
      rd_mux = '0;
      unique case (reg_sel)
         REG_LED:  rd_mux = 32'(led_q);
         REG_SW:   rd_mux = 32'(sw_deb);
         REG_DATA: rd_mux = data_q;
         REG_CTRL: rd_mux = {16'h0, dp_q, en_q};
         default:  rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_high_in) begin
      if (rst_high_in) begin
         led_q       <= '0;
         data_q      <= '0;
         en_q        <= '0;
         dp_q        <= '0;
         rd_data_out <= '0;
      end else begin
         if (rd) rd_data_out <= rd_mux;
         if (wr) begin
            unique case (reg_sel)
               REG_LED:
                  led_q <= wr_data_in[NUM_LED-1:0];
               REG_SW: ;
               REG_DATA:
                  data_q <= wr_data_in & DATA_MASK;
               REG_CTRL: begin
                  en_q <= wr_data_in[7:0] & DIG_MASK;
                  dp_q <= wr_data_in[15:8] & DIG_MASK;
               end
               default: ;
            endcase
         end
      end
   end

   // A bit only moves when two consecutive samples agree.
   assign db_tc    = (db_cnt == DB_LAST);
   assign sw_agree = ~(sw_sync ^ sw_samp);
   assign sw_deb_n = (sw_deb & ~sw_agree)
                   | (sw_sync & sw_agree);

   always_ff @(posedge clk_in or posedge rst_high_in) begin
      if (rst_high_in) begin
         sw_meta     <= '0;
         sw_sync     <= '0;
         sw_samp     <= '0;
         sw_deb      <= '0;
         db_cnt      <= '0;
         sw_change_q <= 1'b0;
      end else begin
         sw_meta     <= sw_in;
         sw_sync     <= sw_meta;
         sw_change_q <= 1'b0;
         if (db_tc) begin
            db_cnt      <= '0;
            sw_samp     <= sw_sync;
            sw_deb      <= sw_deb_n;
            sw_change_q <= (sw_deb_n != sw_deb);
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   assign sw_change_out = sw_change_q;
   assign led_out       = led_q;

   sseg_scan #(
      .NUM_DIGITS (NUM_DIGITS),
      .REFRESH_DIV(REFRESH_DIV)
   ) u_scan (
      .clk       (clk_in),
      .rst       (rst_high_in),
      .digit_data(data_q),
      .digit_en  (en_q),
      .digit_dp  (dp_q),
      .sseg      (sseg_out),
      .dp        (dp_out),
      .an        (an_out)
   );

endmodule

// File: tb/tb_io_periph_ctrl.sv
// tb_io_periph_ctrl: directed checks of bus, scan and debounce
// on a small configuration (4 digits, short dividers).
module tb_io_periph_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_high_in;
   logic        cs_in;
   logic [3:0]  addr_in;
   logic [31:0] wr_data_in;
   logic        we_in;
   logic [31:0] rd_data_out;
   logic [15:0] sw_in;
   logic        sw_change_out;
   logic [15:0] led_out;
   logic [6:0]  sseg_out;
   logic        dp_out;
   logic [3:0]  an_out;

   int n_chk = 0;
   int n_err = 0;

   io_periph_ctrl #(
      .NUM_SW      (16),
      .NUM_LED     (16),
      .NUM_DIGITS  (4),
      .REFRESH_DIV (4),
      .DEBOUNCE_DIV(8)
   ) dut (
      .clk_in       (clk_in),
      .rst_high_in  (rst_high_in),
      .cs_in        (cs_in),
      .addr_in      (addr_in),
      .wr_data_in   (wr_data_in),
      .we_in        (we_in),
      .rd_data_out  (rd_data_out),
      .sw_in        (sw_in),
      .sw_change_out(sw_change_out),
      .led_out      (led_out),
      .sseg_out     (sseg_out),
      .dp_out       (dp_out),
      .an_out       (an_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic bus_wr(
      input logic [3:0]  a,
      input logic [31:0] d
   );
      cs_in      = 1'b1;
      we_in      = 1'b1;
      addr_in    = a;
      wr_data_in = d;
      tick();
      cs_in = 1'b0;
      we_in = 1'b0;
   endtask

   task automatic bus_rd(
      input  logic [3:0]  a,
      output logic [31:0] d
   );
      cs_in   = 1'b1;
      we_in   = 1'b0;
      addr_in = a;
      tick();
      cs_in = 1'b0;
      d     = rd_data_out;
   endtask

   // Leaves the bench on the first cycle of a digit-0 slot.
   task automatic sync_dig0();
      logic [3:0] prev;
      bit         found;
      found = 1'b0;
      prev  = an_out;
      for (int i = 0; i < 64 && !found; i++) begin
         tick();
         if (an_out == 4'b1110 && prev != 4'b1110)
            found = 1'b1;
         prev = an_out;
      end
      chk("sync_dig0", 32'(found), 32'd1);
   endtask

   logic [31:0] rv;
   logic [3:0]  an_e  [4];
   logic [6:0]  seg_e [4];
   int          pulses;
   int          pulse_at;

   initial begin
      rst_high_in = 1'b1;
      cs_in       = 1'b0;
      we_in       = 1'b0;
      addr_in     = '0;
      wr_data_in  = '0;
      sw_in       = '0;
      tick();
      tick();
      chk("rst_rd",   rd_data_out,       32'h0);
      chk("rst_led",  32'(led_out),      32'h0);
      chk("rst_an",   32'(an_out),       32'hF);
      chk("rst_sseg", 32'(sseg_out),     32'h7F);
      chk("rst_dp",   32'(dp_out),       32'h1);
      chk("rst_swc",  32'(sw_change_out), 32'h0);
      rst_high_in = 1'b0;
      tick();

      // LED / SW register access
      bus_wr(4'h0, 32'h0000_A5A5);
      chk("led_out", 32'(led_out), 32'hA5A5);
      bus_rd(4'h0, rv);
      chk("led_rd", rv, 32'h0000_A5A5);
      tick();
      chk("rd_hold", rd_data_out, 32'h0000_A5A5);
      bus_wr(4'h4, 32'hFFFF_FFFF);
      bus_rd(4'h4, rv);
      chk("sw_ro", rv, 32'h0);
      bus_wr(4'h1, 32'hFFFF_FFFF);
      chk("led_all", 32'(led_out), 32'hFFFF);
      bus_rd(4'h3, rv);
      chk("led_upper", rv, 32'h0000_FFFF);

      // Absent-digit bits read 0
      bus_wr(4'h8, 32'hFFFF_4321);
      bus_rd(4'h8, rv);
      chk("data_mask", rv, 32'h0000_4321);
      bus_wr(4'hC, 32'hFFFF_FFFF);
      bus_rd(4'hC, rv);
      chk("ctrl_mask", rv, 32'h0000_0F0F);

      // Full scan, all digits on, no dp
      bus_wr(4'hC, 32'h0000_000F);
      an_e  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      seg_e = '{7'h79, 7'h24, 7'h30, 7'h19};
      sync_dig0();
      for (int k = 0; k < 4; k++) begin
         for (int s = 0; s < 4; s++) begin
            chk($sformatf("scan_an%0d_%0d", k, s),
                32'(an_out), 32'(an_e[k]));
            chk($sformatf("scan_seg%0d_%0d", k, s),
                32'(sseg_out), 32'(seg_e[k]));
            tick();
         end
      end
      chk("wrap_an",  32'(an_out),   32'hE);
      chk("wrap_seg", 32'(sseg_out), 32'h79);
      chk("wrap_dp",  32'(dp_out),   32'h1);

      // Digits 1,3 off; dp requested on disabled digit 1
      bus_wr(4'hC, 32'h0000_0205);
      an_e  = '{4'b1110, 4'b1111, 4'b1011, 4'b1111};
      seg_e = '{7'h79, 7'h7F, 7'h30, 7'h7F};
      sync_dig0();
      tick();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("mask_an%0d", k),
             32'(an_out), 32'(an_e[k]));
         chk($sformatf("mask_seg%0d", k),
             32'(sseg_out), 32'(seg_e[k]));
         chk($sformatf("mask_dp%0d", k),
             32'(dp_out), 32'h1);
         for (int s = 0; s < 4; s++) tick();
      end

      // dp on an enabled digit
      bus_wr(4'hC, 32'h0000_0401);
      an_e = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
      sync_dig0();
      chk("dp_d0_off", 32'(dp_out), 32'h1);
      for (int s = 0; s < 8; s++) tick();
      chk("dp_d2_dis", 32'(dp_out), 32'h1);
      bus_wr(4'hC, 32'h0000_0101);
      sync_dig0();
      chk("dp_d0_on", 32'(dp_out), 32'h0);

      // Write + read same cycle: no read happens
      bus_rd(4'hC, rv);
      chk("ctrl_rd", rv, 32'h0000_0101);
      bus_wr(4'h8, 32'h0000_ABCD);
      chk("rw_hold", rd_data_out, 32'h0000_0101);
      bus_rd(4'h8, rv);
      chk("rw_new", rv, 32'h0000_ABCD);

      // Asynchronous reset in the middle of a cycle
      bus_wr(4'hC, 32'h0000_000F);
      sync_dig0();
      #3;
      rst_high_in = 1'b1;
      #1;
      chk("arst_led",  32'(led_out),  32'h0);
      chk("arst_rd",   rd_data_out,   32'h0);
      chk("arst_an",   32'(an_out),   32'hF);
      chk("arst_sseg", 32'(sseg_out), 32'h7F);
      chk("arst_dp",   32'(dp_out),   32'h1);
      tick();

      // Debounce: sw[0] bounces 40 cycles then holds 1
      sw_in = '0;
      tick();
      rst_high_in = 1'b0;
      pulses   = 0;
      pulse_at = -1;
      for (int j = 0; j < 70; j++) begin
         if (j < 40) sw_in[0] = 1'(((j + 1) / 3) % 2);
         else        sw_in[0] = 1'b1;
         tick();
         if (sw_change_out) begin
            pulses++;
            if (pulse_at < 0) pulse_at = j + 1;
         end
      end
      chk("swc_count", 32'(pulses),   32'd1);
      chk("swc_cycle", 32'(pulse_at), 32'd56);
      bus_rd(4'h4, rv);
      chk("sw_deb", rv, 32'h1);
      chk("an_blank", 32'(an_out), 32'hF);

      $display("Result: errors=%0d of %0d checks",
               n_err, n_chk);
      $finish;
   end

endmodule
